// File: rtl/or8x4_rr_arbiter.sv
// Round-robin arbiter sharing an 8-lane, 4-bit OR-reduction bus.
// One grant at a time, bursts of up to MAX_BURST beats, then rotate.
module or8x4_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] REQ,
    input  logic [3:0] I0,
    input  logic [3:0] I1,
    input  logic [3:0] I2,
    input  logic [3:0] I3,
    input  logic [3:0] I4,
    input  logic [3:0] I5,
    input  logic [3:0] I6,
    input  logic [3:0] I7,
    output logic [7:0] GNT,
    output logic [3:0] O,
    output logic       O_VALID,
    input  logic       O_READY,
    output logic       BUSY
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    state_t     state;
    state_t     state_n;
    logic [2:0] ptr;
    logic [2:0] ptr_n;
    logic [2:0] g;
    logic [2:0] g_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [7:0] gnt_n;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    logic       beat;
    logic [3:0] bus;
    logic [3:0] lane [8];

    assign lane[0] = I0;
    assign lane[1] = I1;
    assign lane[2] = I2;
    assign lane[3] = I3;
    assign lane[4] = I4;
    assign lane[5] = I5;
    assign lane[6] = I6;
    assign lane[7] = I7;

    // First requester at or after the rotating pointer wins.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && REQ[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        bus = '0;
        for (int i = 0; i < 8; i++) begin
            bus = bus | (lane[i] & {4{GNT[i]}});
        end
    end

    assign O       = bus;
    assign BUSY    = (state == GRANT);
    assign O_VALID = (state == GRANT) && REQ[g];
    assign beat    = O_VALID && O_READY;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        g_n     = g;
        cnt_n   = cnt;
        gnt_n   = GNT;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    g_n     = sel;
                    gnt_n   = 8'b1 << sel;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                // Dropped request or full burst both hand the bus back.
                if (!REQ[g] || (beat && (cnt + 4'd1 == BURST))) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                    ptr_n   = g + 3'd1;
                end else if (beat) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            GNT   <= '0;
            ptr   <= '0;
            g     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            GNT   <= gnt_n;
            ptr   <= ptr_n;
            g     <= g_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_or8x4_rr_arbiter.sv
// Directed bench for or8x4_rr_arbiter: reset, bursts, rotation,
// wrap with early release, backpressure and mid-burst reset.
module tb_or8x4_rr_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] REQ = '0;
    logic [3:0] lane [8];
    logic [7:0] GNT;
    logic [3:0] O;
    logic       O_VALID;
    logic       O_READY = 1'b0;
    logic       BUSY;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] got;
    logic [13:0] exp_v;

    always #5 CLK = ~CLK;

    or8x4_rr_arbiter #(.MAX_BURST(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .REQ(REQ),
        .I0(lane[0]),
        .I1(lane[1]),
        .I2(lane[2]),
        .I3(lane[3]),
        .I4(lane[4]),
        .I5(lane[5]),
        .I6(lane[6]),
        .I7(lane[7]),
        .GNT(GNT),
        .O(O),
        .O_VALID(O_VALID),
        .O_READY(O_READY),
        .BUSY(BUSY)
    );

    assign got = {GNT, O, O_VALID, BUSY};

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        REQ = '0;
        O_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) lane[i] = 4'hF;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (got !== 14'h0) begin
                n_err++;
                $display("FAIL reset_idle c%0d: got %h want %h", c, got, 14'h0);
            end
            n_cmp++;
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        for (int i = 0; i < 8; i++) lane[i] = 4'h0;
        lane[2] = 4'hA;
        REQ = 8'b0000_0100;
        O_READY = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            @(negedge CLK);
            exp_v = {8'h04, 4'hA, 1'b1, 1'b1};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL single_beat%0d: got %h want %h", b, got, exp_v);
            end
            n_cmp++;
        end
        @(negedge CLK);
        if (got !== 14'h0) begin
            n_err++;
            $display("FAIL single_gap: got %h want %h", got, 14'h0);
        end
        n_cmp++;
        @(negedge CLK);
        exp_v = {8'h04, 4'hA, 1'b1, 1'b1};
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL single_regrant: got %h want %h", got, exp_v);
        end
        n_cmp++;
        REQ = '0;
    endtask

    task automatic test_fairness();
        int e;
        do_reset();
        for (int i = 0; i < 8; i++) lane[i] = 4'(i);
        REQ = 8'hFF;
        O_READY = 1'b1;
        for (int gi = 0; gi < 9; gi++) begin
            e = gi % 8;
            for (int b = 1; b <= 4; b++) begin
                @(negedge CLK);
                exp_v = {8'b1 << e, 4'(e), 1'b1, 1'b1};
                if (got !== exp_v) begin
                    n_err++;
                    $display("FAIL rr_g%0d_b%0d: got %h want %h",
                             gi, b, got, exp_v);
                end
                n_cmp++;
            end
            @(negedge CLK);
            if (got !== 14'h0) begin
                n_err++;
                $display("FAIL rr_gap%0d: got %h want %h", gi, got, 14'h0);
            end
            n_cmp++;
        end
        REQ = '0;
    endtask

    task automatic test_wrap_early();
        do_reset();
        for (int i = 0; i < 8; i++) lane[i] = 4'(i + 1);
        O_READY = 1'b1;
        REQ = 8'h40;
        @(negedge CLK);
        if (GNT !== 8'h40) begin
            n_err++;
            $display("FAIL wrap_g6: got %h want %h", GNT, 8'h40);
        end
        n_cmp++;
        REQ = 8'h00;
        @(negedge CLK);
        REQ = 8'h81;
        for (int b = 1; b <= 2; b++) begin
            @(negedge CLK);
            exp_v = {8'h80, 4'h8, 1'b1, 1'b1};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL wrap_g7_b%0d: got %h want %h", b, got, exp_v);
            end
            n_cmp++;
        end
        @(negedge CLK);
        REQ = 8'h01;
        #1;
        if (O_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_drop_valid: got %b want 0", O_VALID);
        end
        n_cmp++;
        @(negedge CLK);
        if (got !== 14'h0) begin
            n_err++;
            $display("FAIL wrap_gap: got %h want %h", got, 14'h0);
        end
        n_cmp++;
        @(negedge CLK);
        exp_v = {8'h01, 4'h1, 1'b1, 1'b1};
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL wrap_g0: got %h want %h", got, exp_v);
        end
        n_cmp++;
        REQ = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) lane[i] = 4'h0;
        lane[5] = 4'h5;
        O_READY = 1'b0;
        REQ = 8'h20;
        exp_v = {8'h20, 4'h5, 1'b1, 1'b1};
        for (int s = 0; s < 7; s++) begin
            @(negedge CLK);
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL bp_stall%0d: got %h want %h", s, got, exp_v);
            end
            n_cmp++;
        end
        O_READY = 1'b1;
        for (int b = 2; b <= 4; b++) begin
            @(negedge CLK);
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL bp_beat%0d: got %h want %h", b, got, exp_v);
            end
            n_cmp++;
        end
        @(negedge CLK);
        if (got !== 14'h0) begin
            n_err++;
            $display("FAIL bp_release: got %h want %h", got, 14'h0);
        end
        n_cmp++;
        REQ = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) lane[i] = 4'(i);
        O_READY = 1'b1;
        REQ = 8'h02;
        @(negedge CLK);
        REQ = 8'h00;
        @(negedge CLK);
        REQ = 8'h08;
        for (int b = 1; b <= 2; b++) begin
            @(negedge CLK);
            exp_v = {8'h08, 4'h3, 1'b1, 1'b1};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL rst_mid_b%0d: got %h want %h", b, got, exp_v);
            end
            n_cmp++;
        end
        @(negedge CLK);
        RESET = 1'b1;
        REQ = 8'h09;
        @(negedge CLK);
        if (got !== 14'h0) begin
            n_err++;
            $display("FAIL rst_mid_clear: got %h want %h", got, 14'h0);
        end
        n_cmp++;
        RESET = 1'b0;
        @(negedge CLK);
        exp_v = {8'h01, 4'h0, 1'b1, 1'b1};
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL rst_mid_g0: got %h want %h", got, exp_v);
        end
        n_cmp++;
        REQ = '0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) lane[i] = '0;
        test_reset();
        test_single_burst();
        test_fairness();
        test_wrap_early();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
